// File: rtl/ssd_share_arbiter_if.sv
// Bundle between two display requesters and the arbiter that feeds the
// seven-segment driver: request/value/mask in, grants and display fields out.
interface ssd_share_arbiter_if;
    logic        req0;
    logic [15:0] data0;
    logic [3:0]  mask0;
    logic        req1;
    logic [15:0] data1;
    logic [3:0]  mask1;
    logic        gnt0;
    logic        gnt1;
    logic [3:0]  digit0;
    logic [3:0]  digit1;
    logic [3:0]  digit2;
    logic [3:0]  digit3;
    logic [3:0]  mode;
    logic        busy;

    // Arbiter side
    modport slave (
        input  req0, data0, mask0, req1, data1, mask1,
        output gnt0, gnt1, digit0, digit1, digit2, digit3, mode, busy
    );

    // Requester / test-logic side
    modport master (
        output req0, data0, mask0, req1, data1, mask1,
        input  gnt0, gnt1, digit0, digit1, digit2, digit3, mode, busy
    );
endinterface

// File: rtl/ssd_share_arbiter.sv
// Round-robin owner of the shared 4-digit seven-segment display.
// Each grant is held for at least HOLD_CYCLES cycles; while the owner keeps
// requesting, its value refreshes live, otherwise the last value is frozen
// until the hold time runs out. All outputs are registered.
module ssd_share_arbiter #(
    parameter int HOLD_CYCLES = 100000000,
    parameter int CNT_W       = 27
) (
    input  logic                  clk,
    input  logic                  rst,   // active-low, asynchronous
    ssd_share_arbiter_if.slave    bus
);
    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] LP_ONE  = CNT_W'(1);

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_last;     // index of the requester served most recently
    logic              r_gnt0;
    logic              r_gnt1;
    logic              r_busy;
    logic [15:0]       r_digits;
    logic [3:0]        r_mode;

    logic              w_expired;
    logic              w_take0;
    logic              w_take1;
    logic              w_drop;
    logic              w_inc;

    assign w_expired = (r_cnt == LP_LAST);

    // Decide this cycle's ownership action: new grant, release, or keep counting
    always_comb begin
        w_take0 = 1'b0;
        w_take1 = 1'b0;
        w_drop  = 1'b0;
        w_inc   = 1'b0;
        case (r_state)
            IDLE: begin
                // On a tie the requester that was not served last wins
                w_take0 = bus.req0 && (!bus.req1 || r_last);
                w_take1 = bus.req1 && !w_take0;
            end
            OWN0: begin
                w_inc   = !w_expired;
                w_take1 = w_expired && bus.req1;
                w_drop  = w_expired && !bus.req1 && !bus.req0;
            end
            OWN1: begin
                w_inc   = !w_expired;
                w_take0 = w_expired && bus.req0;
                w_drop  = w_expired && !bus.req0 && !bus.req1;
            end
            default: ;
        endcase
    end

    // Ownership state machine with registered grants and display fields
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_last   <= 1'b1;
            r_gnt0   <= 1'b0;
            r_gnt1   <= 1'b0;
            r_busy   <= 1'b0;
            r_digits <= '0;
            r_mode   <= '0;
        end else if (w_take0) begin
            r_state  <= OWN0;
            r_cnt    <= '0;
            r_last   <= 1'b0;
            r_gnt0   <= 1'b1;
            r_gnt1   <= 1'b0;
            r_busy   <= 1'b1;
            r_digits <= bus.data0;
            r_mode   <= bus.mask0;
        end else if (w_take1) begin
            r_state  <= OWN1;
            r_cnt    <= '0;
            r_last   <= 1'b1;
            r_gnt0   <= 1'b0;
            r_gnt1   <= 1'b1;
            r_busy   <= 1'b1;
            r_digits <= bus.data1;
            r_mode   <= bus.mask1;
        end else if (w_drop) begin
            // Display blanks on release; digits are don't-care while idle
            r_state  <= IDLE;
            r_gnt0   <= 1'b0;
            r_gnt1   <= 1'b0;
            r_busy   <= 1'b0;
            r_mode   <= '0;
        end else begin
            // Counter saturates at expiry so a lone owner can keep the display
            if (w_inc) begin
                r_cnt <= r_cnt + LP_ONE;
            end
            // Live refresh only while the owner still requests; else frozen
            if (r_state == OWN0 && bus.req0) begin
                r_digits <= bus.data0;
                r_mode   <= bus.mask0;
            end else if (r_state == OWN1 && bus.req1) begin
                r_digits <= bus.data1;
                r_mode   <= bus.mask1;
            end
        end
    end

    assign bus.gnt0   = r_gnt0;
    assign bus.gnt1   = r_gnt1;
    assign bus.busy   = r_busy;
    assign bus.mode   = r_mode;
    assign bus.digit0 = r_digits[3:0];
    assign bus.digit1 = r_digits[7:4];
    assign bus.digit2 = r_digits[11:8];
    assign bus.digit3 = r_digits[15:12];
endmodule

// File: tb/tb_ssd_share_arbiter.sv
// Self-checking bench for ssd_share_arbiter with HOLD_CYCLES=4: a table of
// per-cycle vectors, hand-written corner sequences and a randomized run
// against an ownership/age reference model.
module tb_ssd_share_arbiter;
    localparam int HOLD = 4;

    logic clk;
    logic rst;
    ssd_share_arbiter_if bus ();

    ssd_share_arbiter #(.HOLD_CYCLES(HOLD), .CNT_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] shown();
        return {bus.digit3, bus.digit2, bus.digit1, bus.digit0};
    endfunction

    // ---------------- reference model ----------------
    // owner: -1 idle, 0/1 requester; age: cycles since grant (not saturated)
    int          m_owner;
    int          m_age;
    int          m_last;
    logic [15:0] m_val;
    logic [3:0]  m_mode;

    task automatic m_reset();
        m_owner = -1; m_age = 0; m_last = 1; m_val = '0; m_mode = '0;
    endtask

    task automatic m_grant(input int who);
        m_owner = who; m_age = 0; m_last = who;
        m_val  = (who == 0) ? bus.data0 : bus.data1;
        m_mode = (who == 0) ? bus.mask0 : bus.mask1;
    endtask

    // Apply the arbitration rules to the inputs sampled at this edge
    task automatic m_step();
        logic r_own, r_oth;
        if (m_owner < 0) begin
            if (bus.req0 && bus.req1) m_grant(1 - m_last);
            else if (bus.req0)        m_grant(0);
            else if (bus.req1)        m_grant(1);
        end else begin
            r_own = (m_owner == 0) ? bus.req0 : bus.req1;
            r_oth = (m_owner == 0) ? bus.req1 : bus.req0;
            if (m_age >= HOLD - 1 && r_oth) begin
                m_grant(1 - m_owner);
            end else if (m_age >= HOLD - 1 && !r_own) begin
                m_owner = -1; m_mode = '0;
            end else begin
                m_age++;
                if (r_own) begin
                    m_val  = (m_owner == 0) ? bus.data0 : bus.data1;
                    m_mode = (m_owner == 0) ? bus.mask0 : bus.mask1;
                end
            end
        end
    endtask

    task automatic m_compare(input int idx);
        string s;
        s = $sformatf("rand[%0d]", idx);
        chk({s, ".gnt0"}, 32'(bus.gnt0), 32'(m_owner == 0));
        chk({s, ".gnt1"}, 32'(bus.gnt1), 32'(m_owner == 1));
        chk({s, ".busy"}, 32'(bus.busy), 32'(m_owner >= 0));
        chk({s, ".mode"}, 32'(bus.mode), 32'(m_mode));
        if (m_owner >= 0) chk({s, ".digits"}, 32'(shown()), 32'(m_val));
    endtask

    // ---------------- helpers ----------------
    task automatic set_in(input logic r0, input logic r1, input logic [15:0] d0,
                          input logic [15:0] d1, input logic [3:0] k0, input logic [3:0] k1);
        bus.req0 = r0; bus.req1 = r1; bus.data0 = d0; bus.data1 = d1;
        bus.mask0 = k0; bus.mask1 = k1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset held across an edge, released at a falling edge
    task automatic do_reset();
        rst = 1'b0;
        tick();
        @(negedge clk);
        rst = 1'b1;
        m_reset();
    endtask

    typedef struct {
        logic        r0, r1;
        logic [15:0] d0, d1;
        logic [3:0]  k0, k1;
        logic        e_g0, e_g1;
        logic [15:0] e_dig;
        logic [3:0]  e_mode;
    } vec_t;

    vec_t tbl[11];

    initial begin
        rst = 1'b1;
        set_in(1'b0, 1'b0, 16'h0, 16'h0, 4'h0, 4'h0);

        // Per-cycle expectations after each edge, starting from idle
        tbl[0]  = '{1, 0, 16'hBEEF, 16'h0000, 4'hF, 4'h0, 1, 0, 16'hBEEF, 4'hF};
        tbl[1]  = '{0, 0, 16'hBEEF, 16'h0000, 4'hF, 4'h0, 1, 0, 16'hBEEF, 4'hF};
        tbl[2]  = '{0, 0, 16'h1111, 16'h0000, 4'h1, 4'h0, 1, 0, 16'hBEEF, 4'hF};
        tbl[3]  = '{0, 0, 16'h2222, 16'h0000, 4'h2, 4'h0, 1, 0, 16'hBEEF, 4'hF};
        tbl[4]  = '{0, 0, 16'h3333, 16'h0000, 4'h3, 4'h0, 0, 0, 16'h0000, 4'h0};
        tbl[5]  = '{0, 1, 16'h0000, 16'h00FF, 4'h0, 4'h3, 0, 1, 16'h00FF, 4'h3};
        tbl[6]  = '{1, 0, 16'h1234, 16'h9999, 4'hF, 4'hF, 0, 1, 16'h00FF, 4'h3};
        tbl[7]  = '{1, 0, 16'h1234, 16'h9999, 4'hF, 4'hF, 0, 1, 16'h00FF, 4'h3};
        tbl[8]  = '{1, 0, 16'h1234, 16'h9999, 4'hF, 4'hF, 0, 1, 16'h00FF, 4'h3};
        tbl[9]  = '{1, 0, 16'h1234, 16'h9999, 4'hF, 4'hF, 1, 0, 16'h1234, 4'hF};
        tbl[10] = '{1, 0, 16'h5678, 16'h9999, 4'h0, 4'hF, 1, 0, 16'h5678, 4'h0};

        // --- Reset asserted while req0 is high ---
        set_in(1'b1, 1'b0, 16'hBEEF, 16'h0, 4'hF, 4'h0);
        rst = 1'b0;
        tick(); tick();
        chk("rst.gnt0", 32'(bus.gnt0), 32'd0);
        chk("rst.gnt1", 32'(bus.gnt1), 32'd0);
        chk("rst.busy", 32'(bus.busy), 32'd0);
        chk("rst.mode", 32'(bus.mode), 32'h0);
        chk("rst.digits", 32'(shown()), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        chk("rel.gnt0", 32'(bus.gnt0), 32'd1);
        chk("rel.digits", 32'(shown()), 32'hBEEF);
        chk("rel.mode", 32'(bus.mode), 32'hF);

        // --- Table vectors ---
        set_in(1'b0, 1'b0, 16'h0, 16'h0, 4'h0, 4'h0);
        do_reset();
        for (int i = 0; i < 11; i++) begin
            set_in(tbl[i].r0, tbl[i].r1, tbl[i].d0, tbl[i].d1, tbl[i].k0, tbl[i].k1);
            tick();
            chk($sformatf("tbl[%0d].gnt0", i), 32'(bus.gnt0), 32'(tbl[i].e_g0));
            chk($sformatf("tbl[%0d].gnt1", i), 32'(bus.gnt1), 32'(tbl[i].e_g1));
            chk($sformatf("tbl[%0d].mode", i), 32'(bus.mode), 32'(tbl[i].e_mode));
            if (tbl[i].e_g0 || tbl[i].e_g1)
                chk($sformatf("tbl[%0d].digits", i), 32'(shown()), 32'(tbl[i].e_dig));
        end

        // --- Both requesters high from reset release: alternate every 4 ---
        set_in(1'b1, 1'b1, 16'h1234, 16'hABCD, 4'hF, 4'hF);
        do_reset();
        for (int k = 0; k < 16; k++) begin
            tick();
            chk($sformatf("rr[%0d].gnt0", k), 32'(bus.gnt0), 32'(((k / HOLD) % 2) == 0));
            chk($sformatf("rr[%0d].gnt1", k), 32'(bus.gnt1), 32'(((k / HOLD) % 2) == 1));
            chk($sformatf("rr[%0d].digits", k), 32'(shown()),
                32'((((k / HOLD) % 2) == 0) ? 16'h1234 : 16'hABCD));
            chk($sformatf("rr[%0d].mode", k), 32'(bus.mode), 32'hF);
        end

        // --- req0 alone beyond the hold, counting data; then req1 rises ---
        set_in(1'b1, 1'b0, 16'h0, 16'h0, 4'hF, 4'h1);
        do_reset();
        tick();
        chk("own0.gnt0", 32'(bus.gnt0), 32'd1);
        for (int i = 1; i < 9; i++) begin
            bus.data0 = 16'(i);
            tick();
            chk($sformatf("live[%0d].gnt0", i), 32'(bus.gnt0), 32'd1);
            chk($sformatf("live[%0d].digit0", i), 32'(bus.digit0), 32'(i));
        end
        bus.req1 = 1'b1;
        tick();
        chk("late.gnt1", 32'(bus.gnt1), 32'd1);
        chk("late.gnt0", 32'(bus.gnt0), 32'd0);

        // --- Asynchronous reset between edges while OWN1 ---
        set_in(1'b0, 1'b1, 16'h0, 16'h4321, 4'h0, 4'hF);
        do_reset();
        tick();
        chk("pre.gnt1", 32'(bus.gnt1), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("async.gnt1", 32'(bus.gnt1), 32'd0);
        chk("async.busy", 32'(bus.busy), 32'd0);
        chk("async.mode", 32'(bus.mode), 32'h0);
        set_in(1'b1, 1'b1, 16'h1111, 16'h2222, 4'hF, 4'hF);
        @(negedge clk);
        rst = 1'b1;
        tick();
        chk("after.gnt0", 32'(bus.gnt0), 32'd1);
        chk("after.gnt1", 32'(bus.gnt1), 32'd0);

        // --- Randomized run against the reference model ---
        set_in(1'b0, 1'b0, 16'h0, 16'h0, 4'h0, 4'h0);
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            set_in($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                   16'($urandom), 16'($urandom), 4'($urandom), 4'($urandom));
            @(posedge clk);
            m_step();
            #1;
            m_compare(i);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/ssd_share_arbiter.md
Name: ssd_share_arbiter

Overview:
- Shares the single 4-digit seven-segment display between two requesters, e.g. the operand view and the product view of the carry-save multiplier test top.
- Each requester presents a 16-bit hex value and a 4-bit digit-enable mask.
- The block grants the display round-robin, holds each grant for a minimum visible time, and drives the digit0..digit3/mode inputs of the display driver.
- It sits between the test logic and the seven-segment driver; all outputs are registered.

Parameters:
- HOLD_CYCLES, 100000000, minimum cycles a grant is held (1 s at 100 MHz); legal range 2..2^CNT_W-1.
- CNT_W, 27, width of the hold counter.

Ports:
- clk  input  1  system clock, 100 MHz.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- req0  input  1  requester 0 wants the display; level-sensitive.
- data0  input  16  requester 0 value; [3:0] goes to digit0 (rightmost), [15:12] goes to digit3.
- mask0  input  4  requester 0 digit enables; bit i enables digit i.
- req1  input  1  requester 1 request.
- data1  input  16  requester 1 value.
- mask1  input  4  requester 1 digit enables.
- gnt0  output  1  requester 0 owns the display.
- gnt1  output  1  requester 1 owns the display.
- digit0  output  4  digit to the display driver.
- digit1  output  4  digit to the display driver.
- digit2  output  4  digit to the display driver.
- digit3  output  4  digit to the display driver.
- mode  output  4  digit enables to the display driver.
- busy  output  1  high when either grant is asserted.

Behaviour:
- Reset (rst low, asynchronous): state IDLE, gnt0=gnt1=0, busy=0, digit0..3=0, mode=0000 (display blank), hold counter 0, last_served=1 so requester 0 wins first.
- State machine: IDLE, OWN0, OWN1. Exactly one of gnt0/gnt1 is high in OWNx, none in IDLE; busy = gnt0|gnt1.
- IDLE:
  - Only req0 high -> OWN0 on the next edge.
  - Only req1 high -> OWN1 on the next edge.
  - Both high -> grant the requester that is not last_served.
  - Neither high -> stay in IDLE; mode stays 0000.
- Grant latency:
  - The request is sampled at edge N; gnt, digits and mode are updated at edge N.
  - They are visible one cycle after the request is first seen high.
  - The counter loads 0 on grant entry, and last_served is set to the granted index.
- OWNx, while reqx is high:
  - digits/mode follow datax/maskx every cycle (live refresh, one-cycle registered delay).
- OWNx, when reqx drops before the hold expires:
  - The last registered digits/mode are frozen until expiry; the minimum visible time is honoured.
- Hold counter: increments every cycle in OWNx and saturates at HOLD_CYCLES-1. Expiry is the cycle the counter equals HOLD_CYCLES-1.
- At expiry or any later cycle, in OWNx:
  - Other requester's req high -> switch directly to OWNy. The counter reloads 0, last_served=y, and digits/mode load datay/masky on the same edge (no blank gap).
  - Otherwise reqx low -> IDLE. gnt drops and mode=0000 on that edge.
  - Otherwise (reqx high, other idle) -> remain in OWNx indefinitely with the counter saturated. A later request from the other side is served on the next edge.
- Round-robin fairness: with both requesters continuously high, ownership alternates every HOLD_CYCLES cycles exactly.
- A request pulse shorter than one cycle that is not sampled at an edge is ignored. A request sampled for one cycle gets a full HOLD_CYCLES grant.
- Reset mid-grant: all outputs return to reset values immediately, with no wait for a clock edge.
- Masks are passed through unmodified; mask=0000 with an active grant blanks the display while still holding ownership.

Test Plan (HOLD_CYCLES=4 in simulation):
- Reset with rst=0 while req0=1 -> gnt0=gnt1=0, mode=0000, digits=0. After rst goes to 1, gnt0=1 one edge later, {digit3..0}=data0=16'hBEEF, mode=mask0=1111.
- req0 and req1 both held high from reset release -> gnt0 for 4 cycles, then gnt1 for 4 cycles, alternating. The digits switch between 16'h1234 and 16'hABCD with no cycle of mode=0000.
- req1 pulsed for one cycle with data1=16'h00FF, mask1=0011 -> gnt1 high exactly 4 cycles, mode=0011, digits hold 16'h00FF, then IDLE with mode=0000.
- req0 held alone beyond 4 cycles while data0 counts 0,1,2,... -> gnt0 stays high, digit0 tracks data0 with one-cycle lag. When req1 rises, gnt1 asserts on the next edge.
- rst asserted asynchronously mid-OWN1 between clock edges -> gnt1, busy, and mode clear immediately. After release with req0=req1=1, requester 0 is granted first.
